// File: rtl/jam_cost_rom_if.sv
// Bus bundle between JAM and its cost table: W/J lookup plus the streaming table-load port.
interface jam_cost_rom_if #(
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned COST_W = 7,
   parameter int unsigned SUM_W  = 13
);
   logic [IDX_W-1:0]  W;
   logic [IDX_W-1:0]  J;
   logic [COST_W-1:0] Cost;
   logic              LdStart;
   logic              LdValid;
   logic [COST_W-1:0] LdData;
   logic              LdReady;
   logic              Loaded;
   logic              LdErr;
   logic [SUM_W-1:0]  LdSum;

   modport slave (
      input  W, J, LdStart, LdValid, LdData,
      output Cost, LdReady, Loaded, LdErr, LdSum
   );

   modport master (
      output W, J, LdStart, LdValid, LdData,
      input  Cost, LdReady, Loaded, LdErr, LdSum
   );
endinterface

// File: rtl/jam_cost_rom.sv
// N x N cost table for JAM: one-cycle registered-address lookup, filled by a row-major streaming load.
module jam_cost_rom #(
   parameter int unsigned N      = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned COST_W = 7,
   parameter int unsigned SUM_W  = 13
) (
   input  logic CLK,
   input  logic RST,
   jam_cost_rom_if.slave bus
);
   localparam int unsigned DEPTH = N * N;
   localparam int unsigned PTR_W = 2 * IDX_W;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q;
   logic [SUM_W-1:0]  sum_q;
   logic              loaded_q;
   logic              err_q;
   logic [IDX_W-1:0]  w_s, j_s;
   logic [COST_W-1:0] mem [DEPTH];

   logic accept_c;
   logic last_c;
   logic err_set_c;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // LdStart wins over everything and drops any data presented alongside it
   always_comb begin
      state_d   = state_q;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      err_set_c = 1'b0;
      accept_c  = bus.LdValid && (state_q == LOAD) && !bus.LdStart;
      last_c    = (ptr_q == PTR_W'(DEPTH - 1));
      err_set_c = bus.LdValid && (state_q == DONE) && !bus.LdStart;
      if (bus.LdStart)
         state_d = LOAD;
      else if (accept_c && last_c)
         state_d = DONE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q    <= '0;
         sum_q    <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         w_s      <= '0;
         j_s      <= '0;
      end else begin
         w_s <= bus.W;
         j_s <= bus.J;
         if (bus.LdStart) begin
            ptr_q    <= '0;
            sum_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            if (accept_c) begin
               ptr_q <= ptr_q + PTR_W'(1);
               sum_q <= sum_q + SUM_W'(bus.LdData);
               if (last_c) loaded_q <= 1'b1;
            end
            if (err_set_c) err_q <= 1'b1;
         end
      end
   end

   // Table storage is deliberately not cleared by reset
   always_ff @(posedge CLK) begin
      if (accept_c && !RST) mem[ptr_q] <= bus.LdData;
   end

   assign bus.LdReady = (state_q == LOAD);
   assign bus.Loaded  = loaded_q;
   assign bus.LdErr   = err_q;
   assign bus.LdSum   = sum_q;
   assign bus.Cost    = loaded_q ? mem[{w_s, j_s}] : '0;
endmodule

// File: tb/tb_jam_cost_rom.sv
// Randomized self-checking bench for jam_cost_rom against a table-level reference model.
module tb_jam_cost_rom;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jam_cost_rom_if bus ();
   jam_cost_rom dut (.CLK(clk), .RST(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   int ref_mem [64];
   int ref_phase;   // 0 idle, 1 loading, 2 complete
   int ref_cnt, ref_sum, ref_loaded, ref_err, ref_w, ref_j;
   int ready_cnt;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_vec++;
      if (got !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_cost();
      return (ref_loaded != 0) ? ref_mem[ref_w * 8 + ref_j] : 0;
   endfunction

   // Apply one cycle of inputs, advance the model at the edge, then check all outputs
   task automatic cycle(input logic r, input logic st, input logic v,
                        input int d, input int w, input int j);
      rst         = r;
      bus.LdStart = st;
      bus.LdValid = v;
      bus.LdData  = 7'(d);
      bus.W       = 3'(w);
      bus.J       = 3'(j);
      @(posedge clk);
      if (r) begin
         ref_phase = 0; ref_cnt = 0; ref_sum = 0; ref_loaded = 0; ref_err = 0;
         ref_w = 0; ref_j = 0;
      end else begin
         ref_w = w; ref_j = j;
         if (st) begin
            ref_phase = 1; ref_cnt = 0; ref_sum = 0; ref_loaded = 0; ref_err = 0;
         end else if (v) begin
            if (ref_phase == 1) begin
               ref_mem[ref_cnt] = d % 128;
               ref_sum += d % 128;
               ref_cnt++;
               if (ref_cnt == 64) begin
                  ref_phase = 2;
                  ref_loaded = 1;
               end
            end else if (ref_phase == 2) begin
               ref_err = 1;
            end
         end
      end
      #1;
      check("cost",    32'(bus.Cost),    exp_cost());
      check("ldready", 32'(bus.LdReady), (ref_phase == 1) ? 1 : 0);
      check("loaded",  32'(bus.Loaded),  ref_loaded);
      check("lderr",   32'(bus.LdErr),   ref_err);
      check("ldsum",   32'(bus.LdSum),   ref_sum);
      if (bus.LdReady === 1'b1) ready_cnt++;
   endtask

   initial begin
      ref_phase = 0; ref_cnt = 0; ref_sum = 0; ref_loaded = 0; ref_err = 0;
      ref_w = 0; ref_j = 0; ready_cnt = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 0;

      // Reset, then lookups and stray LdValid before any load
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 0, 2, 4);
      check("preload_cost", 32'(bus.Cost), 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 127)), 2, 4);
      check("idle_valid_no_err", 32'(bus.LdErr), 0);

      // Full load of mem[k] = k with LdValid held high
      ready_cnt = 0;
      cycle(1'b0, 1'b1, 1'b1, 5, 0, 0);
      for (int k = 0; k < 70; k++) cycle(1'b0, 1'b0, (k < 64), k % 128, 0, 0);
      check("ready_cycles", 32'(ready_cnt), 64);
      check("sum_2016", 32'(bus.LdSum), 2016);
      check("loaded_after_64", 32'(bus.Loaded), 1);

      // Read sweep and back-to-back spot checks
      for (int a = 0; a < 64; a++) cycle(1'b0, 1'b0, 1'b0, 0, a / 8, a % 8);
      check("cost_7_7", 32'(bus.Cost), 63);
      cycle(1'b0, 1'b0, 1'b0, 0, 3, 5);
      check("cost_3_5", 32'(bus.Cost), 29);
      cycle(1'b0, 1'b0, 1'b0, 0, 5, 3);
      check("cost_5_3", 32'(bus.Cost), 43);

      // Reload with LdValid toggling every other cycle
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
      for (int k = 0; k < 128; k++)
         cycle(1'b0, 1'b0, k[0], int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      check("toggle_loaded", 32'(bus.Loaded), 1);
      for (int a = 0; a < 24; a++)
         cycle(1'b0, 1'b0, 1'b0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

      // Mid-load reset after 20 entries, then restart with start+valid together
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
      for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 127)), 0, 0);
      cycle(1'b1, 1'b0, 1'b1, 11, 0, 0);
      check("rst_loaded", 32'(bus.Loaded), 0);
      check("rst_sum", 32'(bus.LdSum), 0);
      check("rst_ready", 32'(bus.LdReady), 0);
      cycle(1'b0, 1'b1, 1'b1, 77, 0, 0);
      check("start_drops_data", 32'(bus.LdSum), 0);
      for (int k = 0; k < 64; k++) cycle(1'b0, 1'b0, 1'b1, (k * 37) % 128, 0, 0);
      check("restart_loaded", 32'(bus.Loaded), 1);

      // Write attempt after load: sticky error, table unchanged
      cycle(1'b0, 1'b0, 1'b1, 99, 0, 0);
      check("done_valid_err", 32'(bus.LdErr), 1);
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
      check("cost_0_0_unchanged", 32'(bus.Cost), 0);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
      check("start_clears_err", 32'(bus.LdErr), 0);
      check("start_clears_loaded", 32'(bus.Loaded), 0);

      // Random mixed traffic
      for (int k = 0; k < 600; k++)
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

      // Final clean load and sweep so randomized table contents are read back
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
      for (int k = 0; k < 64; k++) cycle(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 127)), 0, 0);
      for (int a = 0; a < 64; a++) cycle(1'b0, 1'b0, 1'b0, 0, a / 8, a % 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/jam_cost_rom.md
Name: jam_cost_rom

Overview:
Synthesizable cost-table responder for the JAM job-assignment engine: it is the table side of the W/J -> Cost lookup protocol.
- JAM drives worker index W and job index J; this block returns the 7-bit Cost of that pairing one clock later.
- The table is filled at bring-up through a streaming load port, replacing the behavioural ROM model used in simulation.
- It sits beside JAM in the integrated top and also serves as a reusable cost source for FPGA/system tests.

Parameters:
N, 8, number of workers = number of jobs (table is N x N)
IDX_W, 3, width of W/J indices (log2 N)
COST_W, 7, width of one cost entry
SUM_W, 13, width of load checksum (holds N*N*(2^COST_W-1))

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
W  input  IDX_W  worker index from JAM
J  input  IDX_W  job index from JAM
Cost  output  COST_W  cost of the (W,J) pair sampled at the previous edge
LdStart  input  1  one-cycle pulse: begin or restart a table load
LdValid  input  1  LdData is valid
LdData  input  COST_W  cost entry, streamed row-major (W0J0..W0J7, W1J0, ...)
LdReady  output  1  block accepts LdData this cycle
Loaded  output  1  all N*N entries written since the last LdStart
LdErr  output  1  sticky: LdValid seen while not in LOAD after a load was started
LdSum  output  SUM_W  running sum of accepted entries

Behaviour:
- Reset is synchronous, active-high:
  - State = IDLE; Loaded = 0, LdErr = 0, LdSum = 0.
  - Write pointer = 0; registered address (W_s, J_s) = 0.
  - Memory contents are not cleared.
- States:
  - IDLE -> LOAD on LdStart.
  - LOAD -> DONE when entry N*N-1 is accepted.
  - DONE -> LOAD on LdStart.
  - Any state -> IDLE on RST.
- LdReady = 1 only in LOAD (Moore output). An entry is accepted when LdValid & LdReady & !LdStart.
  - The entry is written to address ptr = 8*W + J order (ptr counts 0..63).
  - ptr increments; LdSum += LdData, zero-extended.
- LdStart in any state:
  - Sets ptr = 0, LdSum = 0, Loaded = 0, LdErr = 0, and enters LOAD.
  - Data presented in the same cycle is dropped.
  - The first entry can be accepted in the following cycle.
- Accepting the last entry (ptr = N*N-1) sets state = DONE and Loaded = 1 at that edge. ptr wraps to 0 and is not used further.
- LdValid in DONE without LdStart: data ignored, LdErr = 1 until the next LdStart or RST. LdValid in IDLE is ignored with no error.
- Read path (JAM protocol):
  - Every rising edge registers W_s <= W, J_s <= J.
  - Cost = mem[N*W_s + J_s], combinational from the registered address and memory.
  - Latency: the W/J sampled at edge k gives Cost valid after edge k, for the whole cycle k..k+1.
  - No read enable; a new address can be presented every cycle.
- While Loaded = 0, Cost = 0, including during LOAD and after a mid-load reset.
- A write to the entry currently addressed by W_s/J_s changes Cost after that write edge. This can only occur while Loaded = 0, so it is not visible.
- RST in the middle of a load abandons it: Loaded = 0, and a new LdStart plus a full 64-entry load is required.
- Loaded deasserts on LdStart, so Cost reads 0 for the whole reload.

Test Plan:
1. Reset, then LdStart and stream mem[8w+j] = (8w+j) mod 128 with LdValid held high:
   - LdReady is high for exactly 64 cycles.
   - Loaded rises on the edge accepting entry 63.
   - LdSum = 2016.
2. After load, drive W/J sweeping (0,0),(0,1)..(7,7), one per cycle:
   - Cost equals 8W+J of the previous cycle's address, every cycle.
   - (7,7) -> 63; back-to-back (3,5)->(5,3) gives 29 then 43.
3. Before any load, drive W=2, J=4 -> Cost = 0, Loaded = 0. Drive LdValid with no LdStart -> no write, LdErr stays 0.
4. Toggle LdValid every other cycle during a load -> only valid cycles advance ptr. Loaded is set after the 64th accepted entry; LdSum is correct.
5. After 20 accepted entries:
   - Assert RST for 1 cycle -> Loaded = 0, LdSum = 0, LdReady = 0.
   - Restart with LdStart + LdValid in the same cycle -> that data is dropped; the next 64 entries fill the table from address 0.
6. After Loaded = 1:
   - Pulse LdValid with data 99 -> LdErr = 1 and mem unchanged (a read of (0,0) still returns 0).
   - LdStart -> LdErr = 0, Loaded = 0.
